// File: rtl/canvas_write_scheduler.sv
// canvas_write_scheduler
// Owns the single write port of the COLS x ROWS canvas pixel store that the
// VGA controller scans out. Two sources compete for that port: a brush
// requester that paints one cell per request, and an internal fill sequencer
// that walks every cell in raster order to clear or flood the canvas.
// Optionally, writes are only granted during vertical blanking so the visible
// frame never shows a half-updated canvas.
//
// Ports:
//   i_clk          pixel clock, shared with the VGA controller
//   i_reset        synchronous reset, active LOW
//   i_vblank       high while the VGA vertical counter is in blanking
//   i_brush_req    brush level request, held until o_brush_ack
//   i_brush_x/y    brush cell coordinates
//   i_brush_color  brush pixel value
//   o_brush_ack    one-cycle acknowledge (also for out-of-range cells)
//   i_fill_req     start a fill; only looked at while idle
//   i_fill_color   fill value, captured when the fill is accepted
//   o_busy         fill in progress
//   o_fill_done    one-cycle pulse alongside the final fill write
//   o_wr_en        pixel store write strobe
//   o_wr_x/y       write cell coordinates
//   o_wr_data      write pixel value
module canvas_write_scheduler #(
  parameter int COLS        = 40,
  parameter int ROWS        = 30,
  parameter int PIX_W       = 6,
  parameter bit GATE_VBLANK = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_vblank,
  input  logic             i_brush_req,
  input  logic [5:0]       i_brush_x,
  input  logic [4:0]       i_brush_y,
  input  logic [PIX_W-1:0] i_brush_color,
  output logic             o_brush_ack,
  input  logic             i_fill_req,
  input  logic [PIX_W-1:0] i_fill_color,
  output logic             o_busy,
  output logic             o_fill_done,
  output logic             o_wr_en,
  output logic [5:0]       o_wr_x,
  output logic [4:0]       o_wr_y,
  output logic [PIX_W-1:0] o_wr_data
);

  localparam logic [5:0] X_LIMIT = 6'(COLS);
  localparam logic [4:0] Y_LIMIT = 5'(ROWS);
  localparam logic [5:0] LAST_X  = 6'(COLS - 1);
  localparam logic [4:0] LAST_Y  = 5'(ROWS - 1);

  typedef enum logic {
    ST_IDLE,
    ST_FILL
  } state_t;

  state_t           r_state;
  logic [5:0]       r_curX;
  logic [4:0]       r_curY;
  logic [PIX_W-1:0] r_fillColor;

  logic w_permit;
  logic w_brushGrant;
  logic w_fillGrant;
  logic w_brushInRange;
  logic w_lastX;
  logic w_lastCell;

  // Grant decision for this edge. The brush always wins, but never in the
  // cycle its previous acknowledge is still visible: a requester that keeps
  // its level request up for one extra cycle would otherwise be written twice.
  // That gap cycle is free for the fill sequencer.
  always_comb begin
    w_permit       = (GATE_VBLANK == 1'b0) || i_vblank;
    w_brushGrant   = i_brush_req && w_permit && !o_brush_ack;
    w_fillGrant    = (r_state == ST_FILL) && w_permit && !w_brushGrant;
    w_brushInRange = (i_brush_x < X_LIMIT) && (i_brush_y < Y_LIMIT);
    w_lastX        = (r_curX == LAST_X);
    w_lastCell     = w_lastX && (r_curY == LAST_Y);
  end

  // Single registered process: write port outputs, handshakes, fill FSM and
  // cursor. An out-of-range brush is acknowledged so the requester moves on,
  // but the strobe stays low. The write address/data registers simply hold
  // their last value when nothing is written.
  // busy drops on the edge after the final write, i.e. when the fill_done
  // pulse is already showing, unless a new fill is accepted on that same edge.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= ST_IDLE;
      r_curX      <= '0;
      r_curY      <= '0;
      r_fillColor <= '0;
      o_brush_ack <= 1'b0;
      o_fill_done <= 1'b0;
      o_busy      <= 1'b0;
      o_wr_en     <= 1'b0;
      o_wr_x      <= '0;
      o_wr_y      <= '0;
      o_wr_data   <= '0;
    end else begin
      o_brush_ack <= w_brushGrant;
      o_fill_done <= w_fillGrant && w_lastCell;
      o_wr_en     <= w_brushGrant ? w_brushInRange : w_fillGrant;

      if (w_brushGrant && w_brushInRange) begin
        o_wr_x    <= i_brush_x;
        o_wr_y    <= i_brush_y;
        o_wr_data <= i_brush_color;
      end else if (w_fillGrant) begin
        o_wr_x    <= r_curX;
        o_wr_y    <= r_curY;
        o_wr_data <= r_fillColor;
      end

      case (r_state)
        ST_IDLE: begin
          if (i_fill_req) begin
            r_state     <= ST_FILL;
            r_fillColor <= i_fill_color;
            r_curX      <= '0;
            r_curY      <= '0;
            o_busy      <= 1'b1;
          end else if (o_fill_done) begin
            o_busy <= 1'b0;
          end
        end
        ST_FILL: begin
          // The cursor only moves on a fill grant, so a brush grant or a
          // blanking stall leaves the pending cell in place.
          if (w_fillGrant) begin
            if (w_lastCell) begin
              r_state <= ST_IDLE;
              r_curX  <= '0;
              r_curY  <= '0;
            end else if (w_lastX) begin
              r_curX <= '0;
              r_curY <= r_curY + 5'd1;
            end else begin
              r_curX <= r_curX + 6'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_canvas_write_scheduler.sv
// Testbench for canvas_write_scheduler.
// Two instances share every input: instance 0 is built ungated, instance 1
// only writes during vblank. A behavioural model per instance predicts the
// registered outputs after every rising edge; the fill is modelled as a linear
// cell index (column = index mod COLS, row = index div COLS).
module tb_canvas_write_scheduler;

  localparam int COLS  = 40;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  logic       clock = 1'b0;
  // active-low synchronous reset
  logic       reset = 1'b0;
  logic       vblank = 1'b0;
  logic       brushReq = 1'b0;
  logic [5:0] brushX = '0;
  logic [4:0] brushY = '0;
  logic [5:0] brushColor = '0;
  logic       fillReq = 1'b0;
  logic [5:0] fillColor = '0;

  logic [1:0]      ack, busy, done, wrEn;
  logic [1:0][5:0] wrX;
  logic [1:0][4:0] wrY;
  logic [1:0][5:0] wrData;

  int checkCount = 0;
  int failCount  = 0;

  // model state, one slot per instance
  bit         mFilling[2];
  int         mIdx[2];
  logic [5:0] mColor[2];
  logic       eAck[2], eDone[2], eBusy[2], eWrEn[2];
  logic [5:0] eX[2], eData[2];
  logic [4:0] eY[2];
  bit         justReset;

  canvas_write_scheduler #(.COLS(COLS), .ROWS(ROWS), .PIX_W(6), .GATE_VBLANK(1'b0)) dutFree (
    .i_clk(clock), .i_reset(reset), .i_vblank(vblank),
    .i_brush_req(brushReq), .i_brush_x(brushX), .i_brush_y(brushY),
    .i_brush_color(brushColor), .o_brush_ack(ack[0]),
    .i_fill_req(fillReq), .i_fill_color(fillColor),
    .o_busy(busy[0]), .o_fill_done(done[0]),
    .o_wr_en(wrEn[0]), .o_wr_x(wrX[0]), .o_wr_y(wrY[0]), .o_wr_data(wrData[0])
  );

  canvas_write_scheduler #(.COLS(COLS), .ROWS(ROWS), .PIX_W(6), .GATE_VBLANK(1'b1)) dutGated (
    .i_clk(clock), .i_reset(reset), .i_vblank(vblank),
    .i_brush_req(brushReq), .i_brush_x(brushX), .i_brush_y(brushY),
    .i_brush_color(brushColor), .o_brush_ack(ack[1]),
    .i_fill_req(fillReq), .i_fill_color(fillColor),
    .o_busy(busy[1]), .o_fill_done(done[1]),
    .o_wr_en(wrEn[1]), .o_wr_x(wrX[1]), .o_wr_y(wrY[1]), .o_wr_data(wrData[1])
  );

  // free-running clock
  always #5 clock = ~clock;

  // single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // behavioural model of one rising edge, using the inputs as driven now
  task automatic modelEdge();
    bit permit, brushGo, fillGo, wasFilling;
    justReset = !reset;
    for (int g = 0; g < 2; g++) begin
      if (!reset) begin
        mFilling[g] = 0; mIdx[g] = 0; mColor[g] = '0;
        eAck[g] = 0; eDone[g] = 0; eBusy[g] = 0; eWrEn[g] = 0;
        eX[g] = '0; eY[g] = '0; eData[g] = '0;
      end else begin
        permit     = (g == 0) || vblank;
        brushGo    = brushReq && permit && !eAck[g];
        fillGo     = mFilling[g] && permit && !brushGo;
        wasFilling = mFilling[g];
        eAck[g]  = brushGo;
        eDone[g] = 0;
        eWrEn[g] = 0;
        if (brushGo) begin
          if (int'(brushX) < COLS && int'(brushY) < ROWS) begin
            eWrEn[g] = 1; eX[g] = brushX; eY[g] = brushY; eData[g] = brushColor;
          end
        end else if (fillGo) begin
          eWrEn[g] = 1;
          eX[g]    = 6'(mIdx[g] % COLS);
          eY[g]    = 5'(mIdx[g] / COLS);
          eData[g] = mColor[g];
          mIdx[g]++;
          if (mIdx[g] == CELLS) begin
            eDone[g]    = 1;
            mFilling[g] = 0;
          end
        end
        if (!wasFilling && fillReq) begin
          mFilling[g] = 1; mIdx[g] = 0; mColor[g] = fillColor;
        end
        eBusy[g] = mFilling[g] || eDone[g];
      end
    end
  endtask

  // one clock: model the edge, then compare on the falling edge
  task automatic applyStimulus();
    @(posedge clock);
    modelEdge();
    @(negedge clock);
    for (int g = 0; g < 2; g++) begin
      checkOutput($sformatf("g%0d ack", g), 32'(ack[g]), 32'(eAck[g]));
      checkOutput($sformatf("g%0d wr_en", g), 32'(wrEn[g]), 32'(eWrEn[g]));
      checkOutput($sformatf("g%0d fill_done", g), 32'(done[g]), 32'(eDone[g]));
      checkOutput($sformatf("g%0d busy", g), 32'(busy[g]), 32'(eBusy[g]));
      if (eWrEn[g] || justReset) begin
        checkOutput($sformatf("g%0d wr_x", g), 32'(wrX[g]), 32'(eX[g]));
        checkOutput($sformatf("g%0d wr_y", g), 32'(wrY[g]), 32'(eY[g]));
        checkOutput($sformatf("g%0d wr_data", g), 32'(wrData[g]), 32'(eData[g]));
      end
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  // hold a brush request until the gated-instance model acknowledges it
  task automatic brushUntilAck(input logic [5:0] x, input logic [4:0] y, input logic [5:0] c);
    int n;
    brushX = x; brushY = y; brushColor = c; brushReq = 1'b1;
    n = 0;
    while (!eAck[1] && n < 200) begin
      applyStimulus();
      n++;
    end
    checkOutput("brush ack within bound", 32'(n < 200), 32'd1);
    brushReq = 1'b0;
  endtask

  initial begin
    int n;
    $display("[TB] start");

    // reset state
    reset = 1'b0;
    runCycles(3);
    reset = 1'b1;
    runCycles(2);

    // full fill: ungated instance runs, gated one stalls until vblank
    vblank = 1'b0; fillColor = 6'h15; fillReq = 1'b1;
    applyStimulus();
    fillReq = 1'b0;
    runCycles(1205);
    vblank = 1'b1;
    runCycles(1205);

    // single brush write with the request held past the acknowledge
    brushX = 6'd5; brushY = 5'd7; brushColor = 6'h2A; brushReq = 1'b1;
    runCycles(4);
    brushReq = 1'b0;
    runCycles(2);

    // brush preempting a running fill at cursor (10,0)
    fillColor = 6'h0C; fillReq = 1'b1;
    applyStimulus();
    fillReq = 1'b0;
    n = 0;
    while (mIdx[0] != 10 && n < 100) begin
      applyStimulus();
      n++;
    end
    checkOutput("fill reaches (10,0)", 32'(n < 100), 32'd1);
    brushUntilAck(6'd39, 5'd29, 6'h3F);
    runCycles(1200);

    // blanking stall with a held request, then vblank rises
    vblank = 1'b0; brushX = 6'd12; brushY = 5'd3; brushColor = 6'h11; brushReq = 1'b1;
    runCycles(10);
    vblank = 1'b1;
    runCycles(2);
    brushReq = 1'b0;
    runCycles(2);

    // out-of-range brush, then a request withdrawn while blanked
    brushUntilAck(6'd40, 5'd3, 6'h01);
    applyStimulus();
    brushUntilAck(6'd2, 5'd30, 6'h02);
    applyStimulus();
    vblank = 1'b0; brushX = 6'd1; brushY = 5'd1; brushReq = 1'b1;
    runCycles(3);
    brushReq = 1'b0;
    runCycles(3);
    vblank = 1'b1;
    runCycles(2);

    // reset at fill cell 600, then a fresh fill from (0,0)
    fillColor = 6'h2D; fillReq = 1'b1;
    applyStimulus();
    fillReq = 1'b0;
    n = 0;
    while (mIdx[0] != 600 && n < 1000) begin
      applyStimulus();
      n++;
    end
    checkOutput("fill reaches cell 600", 32'(n < 1000), 32'd1);
    reset = 1'b0;
    applyStimulus();
    reset = 1'b1;
    runCycles(5);
    fillColor = 6'h33; fillReq = 1'b1;
    applyStimulus();
    fillReq = 1'b0;
    runCycles(30);

    // randomized traffic: vblank runs, brush handshakes, fills, rare resets
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 15) == 0) vblank = ~vblank;
      if (!brushReq) begin
        if ($urandom_range(0, 3) == 0) begin
          brushReq   = 1'b1;
          brushX     = 6'($urandom_range(0, 45));
          brushY     = 5'($urandom_range(0, 31));
          brushColor = 6'($urandom);
        end
      end else if (eAck[1]) begin
        if ($urandom_range(0, 1) == 0) brushReq = 1'b0;
        else begin
          brushX = 6'($urandom_range(0, 45));
          brushY = 5'($urandom_range(0, 31));
          brushColor = 6'($urandom);
        end
      end else if ($urandom_range(0, 39) == 0) begin
        brushReq = 1'b0;
      end
      fillReq   = ($urandom_range(0, 199) == 0);
      fillColor = 6'($urandom);
      reset     = ($urandom_range(0, 1499) != 0);
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
